bsram_sp_512x36: RTL and testbench

- Single-port synchronous block RAM: 18 Kbit, organised as 512 words x 36 bits.
- Each word holds four 9-bit byte lanes with per-lane write enables.
- Used as the capture/sample buffer behind the ADC shift-in logic.
- The writer packs serial I/Q bits into `di` and pulses `wre`; a reader fetches words through `do`.

---
 rtl/bsram_pkg.sv | 28 ++
 rtl/bsram_out_reg.sv | 17 +
 rtl/bsram_sp_512x36.sv | 78 +++++++
 tb/tb_bsram_sp_512x36.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bsram_pkg.sv
// Shared geometry, address-slice constants and write-mode encoding for the
// 512x36 single-port block RAM.
package bsram_pkg;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned WIDTH  = 36;
  localparam int unsigned LANE_W = 9;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ADDR_W = 14;

  localparam int unsigned IDX_HI = 13;
  localparam int unsigned IDX_LO = 5;
  localparam int unsigned IDX_W  = IDX_HI - IDX_LO + 1;

  typedef enum logic [1:0] {
    WM_NORMAL  = 2'd0,
    WM_THROUGH = 2'd1,
    WM_RBW     = 2'd2
  } wr_mode_e;

  // Expand per-lane enables into a full-width bit mask.
  function automatic logic [WIDTH-1:0] lane_mask(input logic [LANES-1:0] en);
    lane_mask = '0;
    for (int unsigned k = 0; k < LANES; k++)
      lane_mask[k*LANE_W +: LANE_W] = {LANE_W{en[k]}};
  endfunction

endpackage

// File: rtl/bsram_out_reg.sv
// 36-bit register with load enable and asynchronous active-low clear.
module bsram_out_reg
  import bsram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/bsram_sp_512x36.sv
// Single-port 512x36 block RAM with byte-lane writes, selectable write-port
// read behaviour and optional output pipeline register.
module bsram_sp_512x36
  import bsram_pkg::*;
#(
  parameter int unsigned READ_MODE  = 0,
  parameter int unsigned WRITE_MODE = 0,
  parameter int unsigned BYTE_EN    = 0,
  parameter logic [35:0] INIT_VAL   = 36'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [WIDTH-1:0]  di,
  // read data; 'do' is a reserved word in SystemVerilog
  output logic [WIDTH-1:0]  dout
);

  localparam wr_mode_e WM = wr_mode_e'(WRITE_MODE[1:0]);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};

  logic [IDX_W-1:0] idx;
  logic [LANES-1:0] lanes;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged;
  logic             lat_en;
  logic [WIDTH-1:0] lat_d;
  logic [WIDTH-1:0] lat_q;
  logic             unused_ad4;

  assign idx        = ad[IDX_HI:IDX_LO];
  assign unused_ad4 = ad[4];
  assign lanes      = (BYTE_EN != 0) ? ad[LANES-1:0] : '1;
  assign mask       = lane_mask(lanes);
  assign old_word   = mem[idx];
  assign merged     = (old_word & ~mask) | (di & mask);

  // Memory is not touched by reset, so a write coinciding with rst low lands.
  always_ff @(posedge clk) begin
    if (ce && wre) mem[idx] <= merged;
  end

  // Reads and read-before-write both capture the pre-edge word.
  always_comb begin
    lat_en = ce && (!wre || (WM != WM_NORMAL));
    lat_d  = old_word;
    if (wre && (WM == WM_THROUGH)) lat_d = merged;
  end

  bsram_out_reg u_lat (
    .clk (clk),
    .rst (rst),
    .en  (lat_en),
    .d   (lat_d),
    .q   (lat_q)
  );

  generate
    if (READ_MODE != 0) begin : g_pipe
      logic [WIDTH-1:0] pipe_q;
      bsram_out_reg u_pipe (
        .clk (clk),
        .rst (rst),
        .en  (ce),
        .d   (lat_q),
        .q   (pipe_q)
      );
      assign dout = pipe_q;
    end else begin : g_bypass
      assign dout = lat_q;
    end
  endgenerate

endmodule

// File: tb/tb_bsram_sp_512x36.sv
// Three differently configured RAM instances share one stimulus stream and are
// checked against a word-level memory model after every clock edge.
module tb_bsram_sp_512x36;

  logic        clk = 1'b0;
  logic        rst, ce, wre;
  logic [13:0] ad;
  logic [35:0] di;
  logic [35:0] q0, q1, q2;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int          RMD [3] = '{0, 0, 1};
  localparam int          WMD [3] = '{0, 1, 2};
  localparam int          BED [3] = '{0, 1, 1};
  localparam logic [35:0] IVD [3] = '{36'h0, 36'h0_0000_0123, 36'hC_0FFE_E000};

  logic [35:0] mm  [3][512];
  logic [35:0] lat [3];
  logic [35:0] pip [3];

  always #5 clk = ~clk;

  bsram_sp_512x36 #(.READ_MODE(0), .WRITE_MODE(0), .BYTE_EN(0), .INIT_VAL(36'h0)) d0 (
    .clk(clk), .rst(rst), .ce(ce), .wre(wre), .ad(ad), .di(di), .dout(q0));
  bsram_sp_512x36 #(.READ_MODE(0), .WRITE_MODE(1), .BYTE_EN(1), .INIT_VAL(36'h0_0000_0123)) d1 (
    .clk(clk), .rst(rst), .ce(ce), .wre(wre), .ad(ad), .di(di), .dout(q1));
  bsram_sp_512x36 #(.READ_MODE(1), .WRITE_MODE(2), .BYTE_EN(1), .INIT_VAL(36'hC_0FFE_E000)) d2 (
    .clk(clk), .rst(rst), .ce(ce), .wre(wre), .ad(ad), .di(di), .dout(q2));

  function automatic logic [35:0] expv(input int i);
    return (RMD[i] != 0) ? pip[i] : lat[i];
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/d0"}, q0, expv(0));
    chk({tag, "/d1"}, q1, expv(1));
    chk({tag, "/d2"}, q2, expv(2));
  endtask

  // Word-level behaviour of one clock edge for every configuration.
  task automatic model_edge();
    logic [35:0] mask, old, nw, pres;
    for (int i = 0; i < 3; i++) begin
      mask = '0;
      for (int k = 0; k < 4; k++)
        if (BED[i] == 0 || ad[k]) mask[k*9 +: 9] = '1;
      old = mm[i][ad[13:5]];
      nw  = (old & ~mask) | (di & mask);
      if (ce && wre) mm[i][ad[13:5]] = nw;
      if (!rst) begin
        lat[i] = '0;
        pip[i] = '0;
      end else if (ce) begin
        if (!wre)             pres = old;
        else if (WMD[i] == 1) pres = nw;
        else if (WMD[i] == 2) pres = old;
        else                  pres = lat[i];
        pip[i] = lat[i];
        lat[i] = pres;
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic [8:0] a,
                      input logic a4, input logic [3:0] ln, input logic [35:0] d);
    @(negedge clk);
    rst = r; ce = c; wre = w; ad = {a, a4, ln}; di = d;
    @(posedge clk);
    #1;
    model_edge();
    check_all("step");
  endtask

  // Called right after a step's check, so no clock edge is spent.
  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      lat[i] = '0;
      pip[i] = '0;
    end
    chk("rst_d0", q0, 36'h0);
    chk("rst_d1", q1, 36'h0);
    chk("rst_d2", q2, 36'h0);
  endtask

  initial begin
    logic [63:0] r64;
    logic [8:0]  ra;
    for (int i = 0; i < 3; i++) begin
      lat[i] = '0;
      pip[i] = '0;
      for (int w = 0; w < 512; w++) mm[i][w] = IVD[i];
    end
    rst = 1'b0; ce = 1'b0; wre = 1'b0; ad = '0; di = '0;
    #3;
    chk("por_d0", q0, 36'h0);
    chk("por_d1", q1, 36'h0);
    chk("por_d2", q2, 36'h0);
    step(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 4'h0, 36'h0);

    // full-word write then read of word 3
    step(1'b1, 1'b1, 1'b1, 9'd3, 1'b0, 4'hF, 36'h1_2345_6789);
    chk("wt_d1", q1, 36'h1_2345_6789);
    step(1'b1, 1'b1, 1'b0, 9'd3, 1'b0, 4'h0, 36'h0);
    chk("rd_d0", q0, 36'h1_2345_6789);

    // async reset clears outputs, memory survives
    pulse_reset();
    step(1'b1, 1'b1, 1'b0, 9'd3, 1'b0, 4'h0, 36'h0);
    chk("mem_keep", q0, 36'h1_2345_6789);

    // byte lanes on word 10
    step(1'b1, 1'b1, 1'b1, 9'd10, 1'b0, 4'hF, 36'h0);
    step(1'b1, 1'b1, 1'b1, 9'd10, 1'b0, 4'b0101, 36'hF_FFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 9'd10, 1'b0, 4'h0, 36'h0);
    chk("lanes_d1", q1, 36'h0_07FC_01FF);
    chk("lanes_d0", q0, 36'hF_FFFF_FFFF);

    // write modes: old A5 at word 0, last read returns 77 from word 5
    step(1'b1, 1'b1, 1'b1, 9'd0, 1'b0, 4'hF, 36'hA5);
    step(1'b1, 1'b1, 1'b1, 9'd5, 1'b0, 4'hF, 36'h77);
    step(1'b1, 1'b1, 1'b0, 9'd5, 1'b0, 4'h0, 36'h0);
    step(1'b1, 1'b1, 1'b1, 9'd0, 1'b0, 4'hF, 36'h5A);
    chk("wm_normal", q0, 36'h77);
    chk("wm_through", q1, 36'h5A);
    step(1'b1, 1'b1, 1'b0, 9'd5, 1'b0, 4'h0, 36'h0);
    chk("wm_rbw", q2, 36'hA5);

    // pipeline latency: words 0..3 hold 1..4
    for (int w = 0; w < 4; w++)
      step(1'b1, 1'b1, 1'b1, 9'(w), 1'b0, 4'hF, 36'(w + 1));
    step(1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 4'h0, 36'h0);
    for (int w = 1; w < 5; w++) begin
      step(1'b1, 1'b1, 1'b0, 9'((w < 4) ? w : 3), 1'b0, 4'h0, 36'h0);
      chk("pipe", q2, 36'(w));
    end

    // clock enable and last word
    step(1'b1, 1'b0, 1'b1, 9'd511, 1'b0, 4'hF, 36'hFFF);
    chk("ce_hold", q0, 36'h4);
    step(1'b1, 1'b1, 1'b0, 9'd511, 1'b0, 4'h0, 36'h0);
    chk("w511_init", q0, 36'h0);
    step(1'b1, 1'b1, 1'b1, 9'd511, 1'b0, 4'hF, 36'hFFF);
    step(1'b1, 1'b1, 1'b0, 9'd511, 1'b0, 4'h0, 36'h0);
    chk("w511_rd", q0, 36'hFFF);
    step(1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 4'h0, 36'h0);
    chk("w0_kept", q0, 36'h1);

    // randomized traffic, including resets held across write edges
    for (int n = 0; n < 400; n++) begin
      r64 = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       ra = 9'd0;
        1:       ra = 9'd511;
        2:       ra = 9'($urandom_range(0, 7));
        default: ra = 9'($urandom_range(0, 511));
      endcase
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), r64[35:0]);
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
